quad_encoder_decoder: RTL and testbench

- Consumes the encoder_a/encoder_b quadrature pair produced by the BLDC motor emulator, or by a real motor encoder.
- Outputs a signed position count, the direction of the last step, a per-step strobe, a windowed velocity measurement and a sticky illegal-transition flag.
- Sits directly downstream of the motor emulation stage; feeds the speed/position control loop.

---
 rtl/qdec_pkg.sv | 16 +
 rtl/qdec_input_cond.sv | 33 +++
 rtl/quad_encoder_decoder.sv | 71 +++++++
 tb/tb_quad_encoder_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// qdec_pkg: quadrature AB state constants, step classes and the transition decoder
package qdec_pkg;
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;
  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_BWD, STEP_ILLEGAL} step_t;
  function automatic logic [1:0] gray_next(input logic [1:0] x);
    return x == AB_00 ? AB_01 : x == AB_01 ? AB_11 : x == AB_11 ? AB_10 : AB_00;
  endfunction
  function automatic step_t qdec_decode(input logic [1:0] prev_ab, input logic [1:0] ab);
    return ab == prev_ab ? STEP_NONE :
           ab == gray_next(prev_ab) ? STEP_FWD :
           prev_ab == gray_next(ab) ? STEP_BWD : STEP_ILLEGAL;
  endfunction
endpackage

// File: rtl/qdec_input_cond.sv
// qdec_input_cond: per-channel synchronizer plus glitch filter when QDEC_GLITCH_FILTER_EN is defined
module qdec_input_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  logic [SYNC_STAGES-1:0] sync;
  always_ff @(posedge clk)
    if (!reset) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], din};
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic lvl;
  logic [CW-1:0] cnt;
  // a new level is taken on the FILTER_LEN-th consecutive differing sample
  always_ff @(posedge clk)
    if (!reset) begin
      lvl <= 1'b0;
      cnt <= '0;
    end else if (sync[SYNC_STAGES-1] == lvl) cnt <= '0;
    else if (cnt == CW'(FILTER_LEN - 1)) begin
      lvl <= sync[SYNC_STAGES-1];
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
  assign dout = lvl;
`else
  assign dout = sync[SYNC_STAGES-1];
`endif
endmodule

// File: rtl/quad_encoder_decoder.sv
// quad_encoder_decoder: quadrature decoder with position, direction, windowed velocity and error flag; QDEC_GLITCH_FILTER_EN adds input glitch filtering
module quad_encoder_decoder #(
  parameter int DATA_WIDTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 3,
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  encoder_a,
  input  logic                  encoder_b,
  input  logic                  pos_clear,
  input  logic                  err_clear,
  output logic [DATA_WIDTH-1:0] position,
  output logic                  direction,
  output logic                  step_pulse,
  output logic [DATA_WIDTH-1:0] velocity,
  output logic                  velocity_valid,
  output logic                  error
);
  import qdec_pkg::*;
  localparam logic [DATA_WIDTH-1:0] WIN_LAST = DATA_WIDTH'(WINDOW_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] ACC_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] ACC_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic a, b, primed, fwd, bwd, win_last;
  logic [1:0] ab, prev_ab;
  logic [DATA_WIDTH-1:0] acc, acc_next, win_cnt;
  step_t step;
  qdec_input_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_cond_a (
    .clk(clk), .reset(reset), .din(encoder_a), .dout(a));
  qdec_input_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_cond_b (
    .clk(clk), .reset(reset), .din(encoder_b), .dout(b));
  assign ab = {a, b};
  always_comb begin
    step = primed ? qdec_decode(prev_ab, ab) : STEP_NONE;
    fwd = step == STEP_FWD;
    bwd = step == STEP_BWD;
    win_last = win_cnt == WIN_LAST;
    acc_next = fwd ? (acc == ACC_MAX ? acc : acc + 1'b1) :
               bwd ? (acc == ACC_MIN ? acc : acc - 1'b1) : acc;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      primed <= 1'b0;
      prev_ab <= 2'b00;
      position <= '0;
      direction <= 1'b0;
      step_pulse <= 1'b0;
      velocity <= '0;
      velocity_valid <= 1'b0;
      error <= 1'b0;
      acc <= '0;
      win_cnt <= '0;
    end else begin
      primed <= 1'b1;
      prev_ab <= ab;
      step_pulse <= fwd | bwd;
      if (fwd | bwd) direction <= fwd;
      position <= pos_clear ? '0 : fwd ? position + 1'b1 : bwd ? position - 1'b1 : position;
      error <= (step == STEP_ILLEGAL) | (error & ~err_clear);
      velocity_valid <= win_last;
      if (win_last) begin
        velocity <= acc_next;
        acc <= '0;
        win_cnt <= '0;
      end else begin
        acc <= acc_next;
        win_cnt <= win_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_quad_encoder_decoder.sv
// tb_quad_encoder_decoder: table-driven and directed checks of quad_encoder_decoder
module tb_quad_encoder_decoder;
  localparam int SS = 2;
  localparam int FL = 3;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = SS + FL + 1;
`else
  localparam int LAT = SS + 1;
`endif
  logic clk = 1'b0, reset = 1'b0, encoder_a = 1'b0, encoder_b = 1'b0;
  logic pos_clear = 1'b0, err_clear = 1'b0;
  logic [15:0] position, velocity;
  logic direction, step_pulse, velocity_valid, error;
  int errors = 0, checks = 0;
  typedef struct {
    logic [1:0] ab;
    logic pclr;
    logic eclr;
    logic [15:0] pos;
    logic dir;
    logic err;
    int pulses;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  quad_encoder_decoder #(.DATA_WIDTH(16), .SYNC_STAGES(SS), .FILTER_LEN(FL), .WINDOW_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .encoder_a(encoder_a), .encoder_b(encoder_b),
    .pos_clear(pos_clear), .err_clear(err_clear), .position(position), .direction(direction),
    .step_pulse(step_pulse), .velocity(velocity), .velocity_valid(velocity_valid), .error(error));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic [1:0] ab, input logic pclr, input logic eclr,
                     input logic [15:0] pos, input logic dir, input logic err, input int pulses);
    vec_t v;
    v.ab = ab; v.pclr = pclr; v.eclr = eclr; v.pos = pos; v.dir = dir; v.err = err; v.pulses = pulses;
    vecs.push_back(v);
  endtask
  function automatic logic [1:0] nxt(input logic [1:0] x);
    case (x)
      2'b00: return 2'b01;
      2'b01: return 2'b11;
      2'b11: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction
  initial begin
    int n, np, first, k, nv;
    logic [1:0] cur;
    for (int r = 0; r < 3; r++) begin
      add(2'b01, 0, 0, 16'(4 * r + 1), 1, 0, 1);
      add(2'b11, 0, 0, 16'(4 * r + 2), 1, 0, 1);
      add(2'b10, 0, 0, 16'(4 * r + 3), 1, 0, 1);
      add(2'b00, 0, 0, 16'(4 * r + 4), 1, 0, 1);
    end
    add(2'b10, 0, 0, 16'd11, 0, 0, 1); add(2'b11, 0, 0, 16'd10, 0, 0, 1);
    add(2'b01, 0, 0, 16'd9, 0, 0, 1);  add(2'b00, 0, 0, 16'd8, 0, 0, 1);
    add(2'b10, 0, 0, 16'd7, 0, 0, 1);  add(2'b11, 0, 0, 16'd6, 0, 0, 1);
    add(2'b01, 0, 0, 16'd5, 0, 0, 1);  add(2'b00, 0, 0, 16'd4, 0, 0, 1);
    add(2'b00, 1, 0, 16'd0, 0, 0, 0);
    add(2'b10, 0, 0, 16'hFFFF, 0, 0, 1);
    add(2'b00, 0, 0, 16'h0000, 1, 0, 1);
    add(2'b11, 0, 0, 16'h0000, 1, 1, 0);
    add(2'b11, 0, 1, 16'h0000, 1, 0, 0);
    // reset state, then the first window closes 1000 cycles after release
    repeat (3) tick;
    chk("rst_position", position, 0); chk("rst_direction", direction, 0);
    chk("rst_step_pulse", step_pulse, 0); chk("rst_velocity", velocity, 0);
    chk("rst_velocity_valid", velocity_valid, 0); chk("rst_error", error, 0);
    reset = 1'b1;
    np = 0;
    for (n = 1; n <= 1100; n++) begin
      tick;
      np += int'(step_pulse);
      if (velocity_valid) break;
    end
    chk("first_valid_cycle", n, 1000);
    chk("first_velocity", velocity, 0);
    chk("prime_no_step", np, 0);
    foreach (vecs[i]) begin
      encoder_a = vecs[i].ab[1]; encoder_b = vecs[i].ab[0];
      pos_clear = vecs[i].pclr; err_clear = vecs[i].eclr;
      np = 0; first = 0;
      for (int t = 1; t <= 10; t++) begin
        tick;
        if (step_pulse) begin
          np++;
          if (first == 0) first = t;
        end
      end
      pos_clear = 1'b0; err_clear = 1'b0;
      chk($sformatf("vec%0d_position", i), position, vecs[i].pos);
      chk($sformatf("vec%0d_direction", i), direction, vecs[i].dir);
      chk($sformatf("vec%0d_error", i), error, vecs[i].err);
      chk($sformatf("vec%0d_pulses", i), np, vecs[i].pulses);
      if (vecs[i].pulses > 0) chk($sformatf("vec%0d_latency", i), first, LAT);
    end
    // err_clear lands on the same edge as a new illegal jump 11->00
    encoder_a = 1'b0; encoder_b = 1'b0;
    repeat (LAT - 1) tick;
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    chk("err_set_wins", error, 1);
    tick;
    chk("err_sticky", error, 1);
    chk("illegal_pos_hold", position, 0);
`ifdef QDEC_GLITCH_FILTER_EN
    encoder_a = 1'b1;
    repeat (2) tick;
    encoder_a = 1'b0;
    np = 0;
    repeat (12) begin
      tick;
      np += int'(step_pulse);
    end
    chk("glitch2_pulses", np, 0);
    chk("glitch2_position", position, 0);
    encoder_a = 1'b1;
    np = 0; first = 0;
    for (int t = 1; t <= 14; t++) begin
      tick;
      if (t == 3) encoder_a = 1'b0;
      if (step_pulse) begin
        np++;
        if (first == 0) first = t;
        if (np == 1) chk("glitch3_pos_after_step", position, 16'hFFFF);
      end
    end
    chk("glitch3_latency", first, LAT);
    chk("glitch3_pulses", np, 2);
    chk("glitch3_position", position, 0);
`endif
    // align to a window boundary, then 250 steps spread across the next window
    for (n = 1; n <= 1100; n++) begin
      tick;
      if (velocity_valid) break;
    end
    chk("align_valid_seen", n <= 1100, 1);
    cur = 2'b00; k = 0; nv = 0;
    for (int j = 0; j < 2000; j++) begin
      if (k < 250 && j >= 1000 + 4 - LAT && (j - (1000 + 4 - LAT)) % 4 == 0) begin
        cur = nxt(cur);
        encoder_a = cur[1]; encoder_b = cur[0];
        k++;
      end
      pos_clear = (j == 1403);
      tick;
      if (j == 999) begin
        chk("idle_window_valid", velocity_valid, 1);
        chk("idle_window_velocity", velocity, 0);
      end
      if (j >= 1000 && velocity_valid) nv++;
      if (j == 1403) begin
        chk("clr_step_pulse", step_pulse, 1);
        chk("clr_position", position, 0);
      end
    end
    pos_clear = 1'b0;
    chk("vel_valid_count", nv, 1);
    chk("vel_valid_last", velocity_valid, 1);
    chk("velocity_250", velocity, 16'd250);
    chk("pos_after_clear", position, 16'd149);
    // mid-operation reset discards everything and primes again
    reset = 1'b0;
    encoder_a = 1'b0; encoder_b = 1'b0;
    repeat (4) tick;
    chk("rst2_position", position, 0); chk("rst2_velocity", velocity, 0);
    chk("rst2_error", error, 0); chk("rst2_direction", direction, 0);
    reset = 1'b1;
    np = 0;
    repeat (10) begin
      tick;
      np += int'(step_pulse);
    end
    chk("rst2_prime_no_step", np, 0);
    chk("rst2_position_after", position, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
